dispatch_1_to_4: RTL and testbench

Buffered one-to-four dispatcher that owns the routing select of a 1-to-4 demux path in the CRP16 datapath. It accepts tagged words (data plus 2-bit destination) over a valid/ready handshake, queues them in a 2-entry FIFO, and delivers each word to exactly one of four output lanes. Each lane has its own ready, so one stalled consumer holds the queue head without corrupting other traffic. The block sits between a single producer (e.g. result/writeback bus) and four consumers.

---
 rtl/dispatch_1_to_4_if.sv | 47 ++++
 rtl/dispatch_1_to_4.sv | 96 +++++++++
 tb/tb_dispatch_1_to_4.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dispatch_1_to_4_if.sv
// ----------------------------------------------------------------------------
// dispatch_1_to_4_if
// Bundles the producer side and the four consumer lanes of the 1-to-4
// dispatcher into one interface.
//   slave  modport : used by dispatch_1_to_4
//   master modport : used by whoever drives the producer and the lane consumers
// Signals:
//   flush                 synchronous clear of queued words
//   in / in_dest          data word and destination lane (0=w, 1=x, 2=y, 3=z)
//   in_valid / in_ready   producer handshake
//   out_* / valid_*       lane data and lane word valid
//   ready_*               lane consumer accepts
//   count                 words queued (0..2)
// ----------------------------------------------------------------------------
interface dispatch_1_to_4_if;
   localparam int BITS = 16;

   logic            flush;
   logic [BITS-1:0] in;
   logic [1:0]      in_dest;
   logic            in_valid;
   logic            in_ready;

   logic [BITS-1:0] out_w, out_x, out_y, out_z;
   logic            valid_w, valid_x, valid_y, valid_z;
   logic            ready_w, ready_x, ready_y, ready_z;

   logic [1:0]      count;

   modport slave (
      input  flush, in, in_dest, in_valid,
      output in_ready,
      output out_w, out_x, out_y, out_z,
      output valid_w, valid_x, valid_y, valid_z,
      input  ready_w, ready_x, ready_y, ready_z,
      output count
   );

   modport master (
      output flush, in, in_dest, in_valid,
      input  in_ready,
      input  out_w, out_x, out_y, out_z,
      input  valid_w, valid_x, valid_y, valid_z,
      output ready_w, ready_x, ready_y, ready_z,
      input  count
   );
endinterface

// File: rtl/dispatch_1_to_4.sv
// ----------------------------------------------------------------------------
// dispatch_1_to_4
// Buffered one-to-four dispatcher. Tagged words {data, dest} are accepted over
// a valid/ready handshake into a 2-entry FIFO; the head word is presented on
// exactly one lane chosen by its dest tag and pops when that lane is ready.
// Strict FIFO order across all lanes: a stalled head blocks everything behind.
// Ports:
//   clock   rising-edge clock
//   resetn  asynchronous reset, active low
//   bus     dispatch_1_to_4_if.slave (producer handshake, four lanes, count)
// ----------------------------------------------------------------------------
module dispatch_1_to_4 (
   input  logic             clock,
   input  logic             resetn,
   dispatch_1_to_4_if.slave bus
);
   localparam int BITS = 16;

   typedef struct packed {
      logic [BITS-1:0] data;
      logic [1:0]      dest;
   } entry_t;

   entry_t     mem [2];
   logic       rd, wr;
   logic [1:0] count;

   entry_t     head;
   logic       head_valid;
   logic [3:0] lane_ready;
   logic       push, pop;

   assign head       = mem[rd];
   assign head_valid = (count != 2'd0);

   // resetn is folded in so the producer sees in_ready low while reset is held.
   assign bus.in_ready = resetn & (count != 2'd2) & ~bus.flush;
   assign push         = bus.in_valid & bus.in_ready;

   // Only the ready of the lane the head is bound for can pop it.
   assign lane_ready = {bus.ready_z, bus.ready_y, bus.ready_x, bus.ready_w};
   assign pop        = head_valid & lane_ready[head.dest];

   assign bus.count = count;

   // NOTE: every sequential assignment uses <= so all registers update from
   // the same pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         count <= 2'd0;
         rd    <= 1'b0;
         wr    <= 1'b0;
      end else if (bus.flush) begin
         // A pop visible in this cycle is discarded along with the rest.
         count <= 2'd0;
         rd    <= 1'b0;
         wr    <= 1'b0;
      end else begin
         if (push) wr <= ~wr;
         if (pop)  rd <= ~rd;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset; an entry is only observed once count says it
   // was written, so clearing it would buy nothing.
   always_ff @(posedge clock) begin
      if (push) mem[wr] <= '{data: bus.in, dest: bus.in_dest};
   end

   // Lane steering from registered state only, so there is no bypass path and
   // outputs fall asynchronously with reset through count.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      bus.out_w   = '0;
      bus.out_x   = '0;
      bus.out_y   = '0;
      bus.out_z   = '0;
      bus.valid_w = 1'b0;
      bus.valid_x = 1'b0;
      bus.valid_y = 1'b0;
      bus.valid_z = 1'b0;
      if (head_valid) begin
         case (head.dest)
            2'd0: begin bus.out_w = head.data; bus.valid_w = 1'b1; end
            2'd1: begin bus.out_x = head.data; bus.valid_x = 1'b1; end
            2'd2: begin bus.out_y = head.data; bus.valid_y = 1'b1; end
            default: begin bus.out_z = head.data; bus.valid_z = 1'b1; end
         endcase
      end
   end
endmodule

// File: tb/tb_dispatch_1_to_4.sv
// ----------------------------------------------------------------------------
// tb_dispatch_1_to_4
// Self-checking bench for dispatch_1_to_4: a table of per-cycle vectors with
// hand-computed expected outputs, plus hand-written reset sequences.
// ----------------------------------------------------------------------------
module tb_dispatch_1_to_4;
   logic clock;
   logic resetn;

   dispatch_1_to_4_if bus ();

   dispatch_1_to_4 dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual,
                  expected, $time);
      end
   endtask

   // One record per clock cycle. Expected values describe the outputs during
   // the cycle, before the edge that consumes the inputs. rdy/e_valid bit0=w.
   typedef struct {
      string       name;
      logic        vld;
      logic [15:0] data;
      logic [1:0]  dest;
      logic [3:0]  rdy;
      logic        flush;
      logic        e_in_ready;
      logic [3:0]  e_valid;
      logic [15:0] e_data;
      logic [1:0]  e_count;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(string name, logic vld, logic [15:0] data,
                               logic [1:0] dest, logic [3:0] rdy, logic flush,
                               logic e_in_ready, logic [3:0] e_valid,
                               logic [15:0] e_data, logic [1:0] e_count);
      vec_t v;
      v.name = name; v.vld = vld; v.data = data; v.dest = dest; v.rdy = rdy;
      v.flush = flush; v.e_in_ready = e_in_ready; v.e_valid = e_valid;
      v.e_data = e_data; v.e_count = e_count;
      return v;
   endfunction

   task automatic drive(input logic vld, input logic [15:0] data,
                        input logic [1:0] dest, input logic [3:0] rdy,
                        input logic flush);
      bus.in_valid = vld;
      bus.in       = data;
      bus.in_dest  = dest;
      bus.ready_w  = rdy[0];
      bus.ready_x  = rdy[1];
      bus.ready_y  = rdy[2];
      bus.ready_z  = rdy[3];
      bus.flush    = flush;
   endtask

   task automatic check_outputs(input string name, input logic e_in_ready,
                                input logic [3:0] e_valid,
                                input logic [15:0] e_data,
                                input logic [1:0] e_count);
      check({name, ".in_ready"}, 32'(bus.in_ready), 32'(e_in_ready));
      check({name, ".count"}, 32'(bus.count), 32'(e_count));
      check({name, ".valid"},
            32'({bus.valid_z, bus.valid_y, bus.valid_x, bus.valid_w}),
            32'(e_valid));
      check({name, ".out_w"}, 32'(bus.out_w), e_valid[0] ? 32'(e_data) : 32'd0);
      check({name, ".out_x"}, 32'(bus.out_x), e_valid[1] ? 32'(e_data) : 32'd0);
      check({name, ".out_y"}, 32'(bus.out_y), e_valid[2] ? 32'(e_data) : 32'd0);
      check({name, ".out_z"}, 32'(bus.out_z), e_valid[3] ? 32'(e_data) : 32'd0);
   endtask

   initial begin
      // ---------------- Reset held with a word offered ----------------
      resetn = 1'b0;
      drive(1'b1, 16'hDEAD, 2'd1, 4'b1111, 1'b0);
      #3;
      check_outputs("reset_hold", 1'b0, 4'b0000, 16'h0000, 2'd0);
      @(posedge clock); #1;
      check_outputs("reset_hold_edge", 1'b0, 4'b0000, 16'h0000, 2'd0);
      drive(1'b0, 16'h0000, 2'd0, 4'b0000, 1'b0);
      #2 resetn = 1'b1;
      #1;
      check("reset_release.in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clock); #1;

      // ---------------- Vector table ----------------
      // Single dispatch
      vecs.push_back(mk("single_push", 1, 16'hBEEF, 2, 4'b0100, 0, 1, 4'b0000, 16'h0000, 0));
      vecs.push_back(mk("single_out",  0, 16'h0000, 0, 4'b0100, 0, 1, 4'b0100, 16'hBEEF, 1));
      vecs.push_back(mk("single_done", 0, 16'h0000, 0, 4'b0000, 0, 1, 4'b0000, 16'h0000, 0));
      // Backpressure / full
      vecs.push_back(mk("bp_push1",    1, 16'h1111, 0, 4'b0000, 0, 1, 4'b0000, 16'h0000, 0));
      vecs.push_back(mk("bp_push2",    1, 16'h2222, 1, 4'b0000, 0, 1, 4'b0001, 16'h1111, 1));
      vecs.push_back(mk("bp_full",     1, 16'h3333, 2, 4'b0000, 0, 0, 4'b0001, 16'h1111, 2));
      vecs.push_back(mk("bp_wrong_rdy",0, 16'h0000, 0, 4'b0010, 0, 0, 4'b0001, 16'h1111, 2));
      vecs.push_back(mk("bp_pop_w",    0, 16'h0000, 0, 4'b0001, 0, 0, 4'b0001, 16'h1111, 2));
      vecs.push_back(mk("bp_head_x",   0, 16'h0000, 0, 4'b0000, 0, 1, 4'b0010, 16'h2222, 1));
      vecs.push_back(mk("bp_pop_x",    0, 16'h0000, 0, 4'b0010, 0, 1, 4'b0010, 16'h2222, 1));
      vecs.push_back(mk("bp_empty",    0, 16'h0000, 0, 4'b0000, 0, 1, 4'b0000, 16'h0000, 0));
      // Streaming: push word i while word i-1 is on its lane
      for (int i = 0; i < 8; i++) begin
         logic [3:0] ev;
         ev = (i == 0) ? 4'b0000 : 4'(1 << ((i - 1) % 4));
         vecs.push_back(mk($sformatf("stream_%0d", i), 1, 16'hA000 + 16'(i),
                           2'(i % 4), 4'b1111, 0, 1, ev,
                           (i == 0) ? 16'h0000 : 16'hA000 + 16'(i - 1),
                           (i == 0) ? 2'd0 : 2'd1));
      end
      vecs.push_back(mk("stream_last", 0, 16'h0000, 0, 4'b1111, 0, 1, 4'b1000, 16'hA007, 1));
      vecs.push_back(mk("stream_done", 0, 16'h0000, 0, 4'b1111, 0, 1, 4'b0000, 16'h0000, 0));
      // Flush at full with a word offered and a head pop handshake visible
      vecs.push_back(mk("fl_push1",    1, 16'h5555, 3, 4'b0000, 0, 1, 4'b0000, 16'h0000, 0));
      vecs.push_back(mk("fl_push2",    1, 16'h6666, 0, 4'b0000, 0, 1, 4'b1000, 16'h5555, 1));
      vecs.push_back(mk("fl_flush",    1, 16'h7777, 1, 4'b1000, 1, 0, 4'b1000, 16'h5555, 2));
      vecs.push_back(mk("fl_after",    0, 16'h0000, 0, 4'b1111, 0, 1, 4'b0000, 16'h0000, 0));
      // Flush restarts pointers at 0: a new word must still come out cleanly
      vecs.push_back(mk("fl_repush",   1, 16'h8888, 1, 4'b0000, 0, 1, 4'b0000, 16'h0000, 0));
      vecs.push_back(mk("fl_reout",    0, 16'h0000, 0, 4'b0010, 0, 1, 4'b0010, 16'h8888, 1));
      vecs.push_back(mk("fl_reidle",   0, 16'h0000, 0, 4'b0000, 0, 1, 4'b0000, 16'h0000, 0));

      foreach (vecs[i]) begin
         drive(vecs[i].vld, vecs[i].data, vecs[i].dest, vecs[i].rdy, vecs[i].flush);
         #3;
         check_outputs(vecs[i].name, vecs[i].e_in_ready, vecs[i].e_valid,
                       vecs[i].e_data, vecs[i].e_count);
         @(posedge clock); #1;
      end

      // ---------------- Async reset mid-stream ----------------
      drive(1'b1, 16'hC0DE, 2'd3, 4'b0000, 1'b0);
      @(posedge clock); #1;
      drive(1'b0, 16'h0000, 2'd0, 4'b0000, 1'b0);
      #1;
      check_outputs("arst_before", 1'b1, 4'b1000, 16'hC0DE, 2'd1);
      #1 resetn = 1'b0;   // between edges
      #1;
      check_outputs("arst_during", 1'b0, 4'b0000, 16'h0000, 2'd0);
      @(posedge clock); #2;
      resetn = 1'b1;
      #1;
      check_outputs("arst_release", 1'b1, 4'b0000, 16'h0000, 2'd0);
      @(posedge clock); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
